// File: rtl/pid_steer_ctrl_if.sv
// Drive-path bus between the line-error stage and the PID steering controller.
`timescale 1ns/1ps
interface pid_steer_ctrl_if #(
    parameter int unsigned ERR_W = 16,
    parameter int unsigned SPD_W = 12
);
    logic [ERR_W-1:0] error;
    logic             err_vld;
    logic             go;
    logic             line_present;
    logic [SPD_W-1:0] lft_spd;
    logic [SPD_W-1:0] rght_spd;
    logic             spd_vld;
    logic             moving;

    modport master (
        output error, err_vld, go, line_present,
        input  lft_spd, rght_spd, spd_vld, moving
    );

    modport slave (
        input  error, err_vld, go, line_present,
        output lft_spd, rght_spd, spd_vld, moving
    );
endinterface

// File: rtl/pid_steer_ctrl.sv
// PID steering controller: saturated error -> P/I/D terms -> wheel speeds,
// with integrator anti-windup, output clamping and a forward-speed ramp.
`timescale 1ns/1ps
module pid_steer_ctrl #(
    parameter int unsigned      ERR_W       = 16,
    parameter int unsigned      SAT_W       = 11,
    parameter int unsigned      SPD_W       = 12,
    parameter int unsigned      P_COEF      = 3,
    parameter int unsigned      D_COEF      = 2,
    parameter int unsigned      I_SHIFT     = 4,
    parameter int unsigned      FRWRD_STEP  = 4,
    parameter logic [SPD_W-2:0] FRWRD_MAX   = 11'h300,
    parameter logic [SPD_W-2:0] MOVE_THRESH = 11'h080
) (
    input  logic            clk,
    input  logic            rst,
    pid_steer_ctrl_if.slave bus
);
    localparam int unsigned W_ACC = SAT_W + 8;
    localparam int unsigned W_SUM = W_ACC + 2;
    localparam int unsigned FRW_W = SPD_W - 1;
    localparam int unsigned FRX_W = FRW_W + 1;
    localparam int unsigned OUT_W = SPD_W + 1;

    localparam logic signed [ERR_W-1:0] ERR_HI = ERR_W'((2 ** (SAT_W - 1)) - 1);
    localparam logic signed [ERR_W-1:0] ERR_LO = ~ERR_HI;
    localparam logic signed [W_SUM-1:0] PID_HI = W_SUM'((2 ** (SPD_W - 1)) - 1);
    localparam logic signed [W_SUM-1:0] PID_LO = ~PID_HI;
    localparam logic signed [OUT_W-1:0] SPD_HI = OUT_W'((2 ** (SPD_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] SPD_LO = ~SPD_HI;
    localparam logic signed [W_ACC-1:0] P_K    = W_ACC'(P_COEF);
    localparam logic signed [W_ACC-1:0] D_K    = W_ACC'(D_COEF);
    localparam logic [FRX_W-1:0]        STEP_X = FRX_W'(FRWRD_STEP);

    // registered state
    logic signed [SAT_W-1:0] err_sat;
    logic signed [SAT_W-1:0] prev_err;
    logic signed [W_ACC-1:0] p_term;
    logic signed [W_ACC-1:0] i_term;
    logic signed [W_ACC-1:0] d_term;
    logic signed [W_ACC-1:0] integ;
    logic [FRW_W-1:0]        frwrd;
    logic                    vld1;
    logic                    vld2;
    logic                    spd_vld;
    logic signed [SPD_W-1:0] lft_spd;
    logic signed [SPD_W-1:0] rght_spd;

    // combinational helpers
    logic signed [ERR_W-1:0] err_in;
    logic signed [SAT_W-1:0] err_clamp_c;
    logic [FRX_W-1:0]        frwrd_up_c;
    logic [FRW_W-1:0]        frwrd_nxt_c;
    logic signed [W_ACC-1:0] err_ext_c;
    logic signed [W_ACC-1:0] prev_ext_c;
    logic signed [W_ACC-1:0] p_nxt_c;
    logic signed [W_ACC-1:0] d_nxt_c;
    logic signed [W_ACC-1:0] integ_sum_c;
    logic                    integ_ovf_c;
    logic signed [W_SUM-1:0] sum_c;
    logic signed [W_SUM-1:0] sum_sh_c;
    logic signed [SPD_W-1:0] pid_c;
    logic signed [OUT_W-1:0] fw_x_c;
    logic signed [OUT_W-1:0] pid_x_c;
    logic signed [OUT_W-1:0] lft_raw_c;
    logic signed [OUT_W-1:0] rght_raw_c;
    logic                    moving_c;
    logic                    run_c;

    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [OUT_W-1:0] v);
        logic signed [SPD_W-1:0] r;
        r = SPD_W'(v);
        if (v > SPD_HI) begin
            r = SPD_W'(SPD_HI);
        end else if (v < SPD_LO) begin
            r = SPD_W'(SPD_LO);
        end
        return r;
    endfunction

    assign err_in   = bus.error;
    assign moving_c = frwrd > MOVE_THRESH;
    assign run_c    = moving_c && bus.go && bus.line_present;

    // Clamp the raw line error into the SAT_W signed range.
    always_comb begin
        err_clamp_c = SAT_W'(err_in);
        if (err_in > ERR_HI) begin
            err_clamp_c = SAT_W'(ERR_HI);
        end else if (err_in < ERR_LO) begin
            err_clamp_c = SAT_W'(ERR_LO);
        end
    end

    // Forward ramp: climb to the ceiling while go, decay to zero without wrapping otherwise.
    always_comb begin
        frwrd_up_c  = {1'b0, frwrd} + STEP_X;
        frwrd_nxt_c = frwrd;
        if (bus.go) begin
            if (frwrd_up_c > {1'b0, FRWRD_MAX}) begin
                frwrd_nxt_c = FRWRD_MAX;
            end else begin
                frwrd_nxt_c = frwrd_up_c[FRW_W-1:0];
            end
        end else if ({1'b0, frwrd} < STEP_X) begin
            frwrd_nxt_c = '0;
        end else begin
            frwrd_nxt_c = FRW_W'({1'b0, frwrd} - STEP_X);
        end
    end

    // Term arithmetic and integrator overflow detection, all in W_ACC.
    always_comb begin
        err_ext_c   = {{(W_ACC - SAT_W){err_sat[SAT_W-1]}}, err_sat};
        prev_ext_c  = {{(W_ACC - SAT_W){prev_err[SAT_W-1]}}, prev_err};
        p_nxt_c     = err_ext_c * P_K;
        d_nxt_c     = (err_ext_c - prev_ext_c) * D_K;
        integ_sum_c = integ + err_ext_c;
        integ_ovf_c = (integ[W_ACC-1] == err_ext_c[W_ACC-1]) &&
                      (integ_sum_c[W_ACC-1] != integ[W_ACC-1]);
    end

    // Sum the terms, scale down by 8, clamp to speed range and mix with forward speed.
    always_comb begin
        sum_c = {{(W_SUM - W_ACC){p_term[W_ACC-1]}}, p_term} +
                {{(W_SUM - W_ACC){i_term[W_ACC-1]}}, i_term} +
                {{(W_SUM - W_ACC){d_term[W_ACC-1]}}, d_term};
        sum_sh_c = sum_c >>> 3;
        pid_c    = SPD_W'(sum_sh_c);
        if (sum_sh_c > PID_HI) begin
            pid_c = SPD_W'(PID_HI);
        end else if (sum_sh_c < PID_LO) begin
            pid_c = SPD_W'(PID_LO);
        end
        fw_x_c     = {{(OUT_W - FRW_W){1'b0}}, frwrd};
        pid_x_c    = {pid_c[SPD_W-1], pid_c};
        lft_raw_c  = fw_x_c + pid_x_c;
        rght_raw_c = fw_x_c - pid_x_c;
    end

    // Stage 1: capture saturated error and step the forward ramp on each sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sat <= '0;
            frwrd   <= '0;
            vld1    <= 1'b0;
        end else begin
            vld1 <= bus.err_vld;
            if (bus.err_vld) begin
                err_sat <= err_clamp_c;
                frwrd   <= frwrd_nxt_c;
            end
        end
    end

    // Stage 2: register P/I/D terms; integrator clears when not driving and holds on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_term   <= '0;
            i_term   <= '0;
            d_term   <= '0;
            prev_err <= '0;
            integ    <= '0;
            vld2     <= 1'b0;
        end else begin
            vld2 <= vld1;
            if (vld1) begin
                p_term   <= p_nxt_c;
                d_term   <= d_nxt_c;
                i_term   <= integ >>> I_SHIFT;
                prev_err <= err_sat;
            end
            if (!bus.go || !bus.line_present) begin
                integ <= '0;
            end else if (vld1 && moving_c && !integ_ovf_c) begin
                integ <= integ_sum_c;
            end
        end
    end

    // Stage 3: load wheel speeds; steer only while moving with go and a visible line.
    always_ff @(posedge clk) begin
        if (rst) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= vld2;
            if (vld2) begin
                if (run_c) begin
                    lft_spd  <= sat_spd(lft_raw_c);
                    rght_spd <= sat_spd(rght_raw_c);
                end else begin
                    lft_spd  <= {1'b0, frwrd};
                    rght_spd <= {1'b0, frwrd};
                end
            end
        end
    end

    assign bus.lft_spd  = lft_spd;
    assign bus.rght_spd = rght_spd;
    assign bus.spd_vld  = spd_vld;
    assign bus.moving   = moving_c;
endmodule
